// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit frame sequencer: start flag, zero-inserted payload fetched from
// the Tx buffer, stop flag, or an abort pattern; serial line idles at all-ones.
module hdlc_tx_sequencer #(
    parameter int unsigned MAX_BYTES = 126,
    parameter logic [7:0]  FLAG      = 8'h7E
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic [7:0] Tx_FrameSize,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_Data,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done,
    output logic       Tx_SizeErr
);

    localparam logic [7:0] MAX_SIZE = 8'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_START_FLAG,
        S_DATA,
        S_STOP_FLAG,
        S_ABORT
    } state_t;

    state_t     state_q, state_d;
    logic       tx_q, tx_d;
    logic       valid_q, valid_d;
    logic       rd_q, rd_d;
    logic       aborted_q, aborted_d;
    logic       done_q, done_d;
    logic       serr_q, serr_d;
    logic [7:0] size_q, size_d;
    logic [7:0] nread_q, nread_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic [2:0] ones_q, ones_d;
    logic       fin_q, fin_d;

    logic [7:0] cur_byte;
    logic       cur_bit;
    logic [2:0] ones_next;
    logic       size_ok;
    logic       in_frame;

    // A byte read in the previous cycle is consumed straight off Tx_Data so the
    // next bit goes out with no gap; it is captured into shift_q at the same edge.
    assign cur_byte  = rd_q ? Tx_Data : shift_q;
    assign cur_bit   = cur_byte[bit_q];
    assign ones_next = cur_bit ? (ones_q + 3'd1) : 3'd0;
    assign size_ok   = (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= MAX_SIZE);
    assign in_frame  = (state_q == S_PREFETCH) || (state_q == S_START_FLAG) ||
                       (state_q == S_DATA);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d   = state_q;
        tx_d      = 1'b1;
        valid_d   = valid_q;
        rd_d      = 1'b0;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        serr_d    = 1'b0;
        size_d    = size_q;
        nread_d   = nread_q;
        shift_d   = cur_byte;
        bit_d     = bit_q;
        ones_d    = ones_q;
        fin_d     = fin_q;

        unique case (state_q)
            S_IDLE: begin
                if (Tx_Enable) begin
                    if (size_ok) begin
                        state_d   = S_PREFETCH;
                        valid_d   = 1'b1;
                        rd_d      = 1'b1;
                        aborted_d = 1'b0;
                        size_d    = Tx_FrameSize;
                        nread_d   = 8'd1;
                    end else begin
                        serr_d = 1'b1;
                    end
                end
            end
            S_PREFETCH: begin
                state_d = S_START_FLAG;
                bit_d   = 3'd0;
            end
            S_START_FLAG: begin
                tx_d  = FLAG[bit_q];
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = S_DATA;
                    ones_d  = 3'd0;
                    fin_d   = 1'b0;
                end
            end
            S_DATA: begin
                if (ones_q == 3'd5) begin
                    // Inserted zero: payload position holds for one bit time.
                    tx_d   = 1'b0;
                    ones_d = 3'd0;
                    if (fin_q) begin
                        state_d = S_STOP_FLAG;
                        valid_d = 1'b0;
                        bit_d   = 3'd0;
                        fin_d   = 1'b0;
                    end
                end else begin
                    tx_d   = cur_bit;
                    ones_d = ones_next;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (nread_q != size_q) begin
                            rd_d    = 1'b1;
                            nread_d = nread_q + 8'd1;
                        end else if (ones_next == 3'd5) begin
                            fin_d = 1'b1;
                        end else begin
                            state_d = S_STOP_FLAG;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            S_STOP_FLAG: begin
                tx_d  = FLAG[bit_q];
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ABORT: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Abort pattern starts with its zero right away; the seven ones follow.
        if (in_frame && Tx_AbortFrame) begin
            state_d   = S_ABORT;
            tx_d      = 1'b0;
            valid_d   = 1'b0;
            rd_d      = 1'b0;
            nread_d   = nread_q;
            aborted_d = 1'b1;
            bit_d     = 3'd1;
            fin_d     = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            valid_q   <= 1'b0;
            rd_q      <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            serr_q    <= 1'b0;
            size_q    <= 8'd0;
            nread_q   <= 8'd0;
            shift_q   <= 8'd0;
            bit_q     <= 3'd0;
            ones_q    <= 3'd0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            serr_q    <= serr_d;
            size_q    <= size_d;
            nread_q   <= nread_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            ones_q    <= ones_d;
            fin_q     <= fin_d;
        end
    end

    assign Tx              = tx_q;
    assign Tx_ValidFrame   = valid_q;
    assign Tx_RdBuff       = rd_q;
    assign Tx_AbortedTrans = aborted_q;
    assign Tx_Done         = done_q;
    assign Tx_SizeErr      = serr_q;

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Scoreboard bench for hdlc_tx_sequencer: each stimulus pushes the expected
// per-cycle output trace; a negedge monitor pops and compares it.
module tb_hdlc_tx_sequencer;

    localparam logic [7:0] FLAG = 8'h7E;

    typedef struct packed {
        logic tx;
        logic valid;
        logic rd;
        logic done;
        logic aborted;
        logic serr;
    } obs_t;

    typedef struct {
        obs_t v;
        int   cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_enable = 1'b0;
    logic       tx_abort = 1'b0;
    logic [7:0] tx_size = 8'd0;
    logic [7:0] tx_data;
    logic       tx_rdbuff, tx, tx_valid, tx_aborted, tx_done, tx_sizeerr;

    logic [7:0] mem [256];
    logic [7:0] rd_idx = 8'd0;
    logic [7:0] fd [16];

    exp_t  exp_q[$];
    exp_t  e_cur;
    obs_t  got;
    string label = "reset";
    int    checks = 0;
    int    errors = 0;
    logic  exp_aborted = 1'b0;

    hdlc_tx_sequencer dut (
        .Clk             (clk),
        .Rst             (rst_n),
        .Tx_Enable       (tx_enable),
        .Tx_FrameSize    (tx_size),
        .Tx_AbortFrame   (tx_abort),
        .Tx_Data         (tx_data),
        .Tx_RdBuff       (tx_rdbuff),
        .Tx              (tx),
        .Tx_ValidFrame   (tx_valid),
        .Tx_AbortedTrans (tx_aborted),
        .Tx_Done         (tx_done),
        .Tx_SizeErr      (tx_sizeerr)
    );

    always #5 clk = ~clk;

    // Tx buffer: data for the pending read is presented until the strobe edge.
    assign tx_data = mem[rd_idx];
    always @(posedge clk) if (tx_rdbuff) rd_idx <= rd_idx + 8'd1;

    task automatic check(input string name, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got tx/valid/rd/done/aborted/serr=%b, expected %b", name, g, e);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
            got   = {tx, tx_valid, tx_rdbuff, tx_done, tx_aborted, tx_sizeerr};
            check($sformatf("%s cyc%0d", label, e_cur.cyc), got, e_cur.v);
        end
    end

    task automatic push(input obs_t o, input int cyc);
        exp_t e;
        e.v   = o;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Expected trace from the accepting edge (cycle 0): prefetch, idle bit,
    // start flag, stuffed payload, stop flag, idle; optionally cut by an abort.
    task automatic build_exp(input int n, input int abort_at, input int keep);
        obs_t tr[$];
        obs_t o;
        int   ones = 0;
        o = '0; o.tx = 1'b1; o.valid = 1'b1; o.rd = 1'b1;
        tr.push_back(o);
        o.rd = 1'b0;
        tr.push_back(o);
        for (int i = 0; i < 8; i++) begin
            o.tx = FLAG[i];
            tr.push_back(o);
        end
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                o.tx = fd[k][b];
                o.rd = (b == 7) && (k < n - 1);
                tr.push_back(o);
                o.rd = 1'b0;
                ones = o.tx ? ones + 1 : 0;
                if (ones == 5) begin
                    o.tx = 1'b0;
                    tr.push_back(o);
                    ones = 0;
                end
            end
        end
        o = tr[tr.size() - 1];
        o.valid = 1'b0;
        tr[tr.size() - 1] = o;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o.tx   = FLAG[i];
            o.done = (i == 7);
            tr.push_back(o);
        end
        o = '0; o.tx = 1'b1;
        tr.push_back(o);
        tr.push_back(o);
        if (abort_at > 0) begin
            while (tr.size() > abort_at) void'(tr.pop_back());
            o = '0; o.aborted = 1'b1;
            tr.push_back(o);
            for (int i = 1; i < 8; i++) begin
                o.tx   = 1'b1;
                o.done = (i == 7);
                tr.push_back(o);
            end
            o.done = 1'b0;
            tr.push_back(o);
            tr.push_back(o);
        end
        if (keep > 0) while (tr.size() > keep) void'(tr.pop_back());
        for (int i = 0; i < tr.size(); i++) push(tr[i], i);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                $display("FAIL drain: %0d expected cycles never observed", exp_q.size());
                $fatal(1, "drain bound expired");
            end
        end
        @(negedge clk);
    endtask

    task automatic load_buf(input int n);
        for (int k = 0; k < n; k++) mem[rd_idx + 8'(k)] = fd[k];
    endtask

    task automatic run_frame(input string name, input int n, input int abort_at,
                             input int ign_abort_at, input int ign_en_at,
                             input logic abort_with_en);
        label = name;
        load_buf(n);
        @(negedge clk);
        tx_enable = 1'b1;
        tx_size   = 8'(n);
        tx_abort  = abort_with_en;
        @(posedge clk);
        build_exp(n, abort_at, 0);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            tx_enable = (c == ign_en_at);
            tx_abort  = (c == abort_at) || (c == ign_abort_at);
        end
        tx_enable = 1'b0;
        tx_abort  = 1'b0;
        drain();
        exp_aborted = (abort_at > 0);
    endtask

    task automatic run_sizeerr(input string name, input logic [7:0] size);
        obs_t o;
        label = name;
        @(negedge clk);
        tx_enable = 1'b1;
        tx_size   = size;
        @(posedge clk);
        o = '0; o.tx = 1'b1; o.aborted = exp_aborted; o.serr = 1'b1;
        push(o, 0);
        o.serr = 1'b0;
        push(o, 1);
        push(o, 2);
        @(negedge clk);
        tx_enable = 1'b0;
        drain();
    endtask

    initial begin
        obs_t o;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) fd[i] = 8'h00;

        #2 rst_n = 1'b0;
        o = '0; o.tx = 1'b1;
        push(o, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        drain();

        // Reset pulse during byte 2 of a 4-byte frame; outputs clear before the next edge.
        label = "rst_mid";
        load_buf(4);
        @(negedge clk);
        tx_enable = 1'b1;
        tx_size   = 8'd4;
        @(posedge clk);
        build_exp(4, -1, 20);
        o = '0; o.tx = 1'b1;
        push(o, 20);
        push(o, 21);
        push(o, 22);
        @(negedge clk);
        tx_enable = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain();

        fd[0] = 8'h00; fd[1] = 8'hA5;
        run_frame("size2_00_a5", 2, -1, -1, 5, 1'b1);

        fd[0] = 8'hFF;
        run_frame("size1_ff", 1, -1, 22, 20, 1'b0);

        fd[0] = 8'hF8; fd[1] = 8'h03; fd[2] = 8'hFF;
        run_frame("size3_span", 3, -1, -1, 30, 1'b0);

        for (int i = 0; i < 10; i++) fd[i] = 8'h55;
        run_frame("abort_byte2", 10, 21, -1, -1, 1'b0);

        run_sizeerr("size0", 8'd0);
        run_sizeerr("size127", 8'd127);

        fd[0] = 8'h3C; fd[1] = 8'h7E;
        run_frame("after_abort", 2, -1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
